// File: rtl/alien_grid_if.sv
// Bullet/collision link between the player bullet stage (master) and the alien grid (slave).
// bullet_flying qualifies bullet_x/bullet_y every cycle (no backpressure); hit is a one-cycle registered pulse that retires the bullet.
interface alien_grid_if;
   logic       bullet_flying;
   logic [4:0] bullet_x;
   logic [3:0] bullet_y;
   logic       hit;

   modport master (output bullet_flying, bullet_x, bullet_y, input hit);
   modport slave  (input bullet_flying, bullet_x, bullet_y, output hit);
endinterface

// File: rtl/alien_grid.sv
// Invader formation: alive bitmap, marching offsets, bullet collision, scoring,
// wave reload and landing detection. FSM state is exported on dbg_state_o.
module alien_grid #(
   parameter int ROWS        = 4,
   parameter int COLS        = 8,
   parameter int STEP_CYCLES = 18000000,
   parameter int LAND_ROW    = 12
) (
   input  logic                 clk_36MHz,
   input  logic                 reset,
   input  logic                 enable,
   alien_grid_if.slave          bus,
   output logic [ROWS*COLS-1:0] alive,
   output logic [4:0]           offset_x,
   output logic [3:0]           offset_y,
   output logic [7:0]           score,
   output logic                 wave_cleared,
   output logic                 game_over,
   output logic [1:0]           dbg_state_o
);
   localparam int N  = ROWS * COLS;
   localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

   localparam logic [1:0] S_MARCH   = 2'd0;
   localparam logic [1:0] S_CLEARED = 2'd1;
   localparam logic [1:0] S_OVER    = 2'd2;
   localparam logic DIR_RIGHT = 1'b0;
   localparam logic DIR_LEFT  = 1'b1;

   logic [1:0]    state_q, state_d;
   logic          dir_q, dir_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [N-1:0]  alive_q, alive_d;
   logic [4:0]    ox_q, ox_d;
   logic [3:0]    oy_q, oy_d;
   logic [7:0]    score_q, score_d;
   logic          hit_q, hit_d;
   logic          wc_q, wc_d;
   logic          go_q, go_d;

   logic [COLS-1:0] col_any;
   logic [ROWS-1:0] row_any;
   logic [2:0]      cmin, cmax, rmax;
   logic [N-1:0]    kill;
   logic [5:0]      col_rel, right_edge, left_edge;
   logic [4:0]      row_rel;
   logic            step, land;

   always_comb begin
      col_any = '0;
      row_any = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (alive_q[r*COLS+c]) begin
               col_any[c] = 1'b1;
               row_any[r] = 1'b1;
            end
         end
      end
      cmin = '0;
      cmax = '0;
      rmax = '0;
      for (int c = COLS-1; c >= 0; c--) if (col_any[c]) cmin = 3'(c);
      for (int c = 0; c < COLS; c++)    if (col_any[c]) cmax = 3'(c);
      for (int r = 0; r < ROWS; r++)    if (row_any[r]) rmax = 3'(r);
   end

   // Two's-complement differences: a negative offset sets the top bit, so plain
   // equality against the small non-negative slot positions rejects it.
   assign col_rel = {1'b0, bus.bullet_x} - {1'b0, ox_q};
   assign row_rel = {1'b0, bus.bullet_y} - {1'b0, oy_q};

   always_comb begin
      kill = '0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            if (bus.bullet_flying && row_rel == 5'(r) && col_rel == 6'(2*c))
               kill[r*COLS+c] = alive_q[r*COLS+c];
         end
      end
   end

   assign right_edge = {1'b0, ox_q} + {2'b00, cmax, 1'b0};
   assign left_edge  = {1'b0, ox_q} + {2'b00, cmin, 1'b0};
   assign land       = ({1'b0, oy_q} + {2'b00, rmax}) >= 5'(LAND_ROW);
   assign step       = enable && (state_q != S_OVER) && (cnt_q == CW'(STEP_CYCLES-1));

   always_comb begin
      state_d = state_q;
      dir_d   = dir_q;
      cnt_d   = cnt_q;
      alive_d = alive_q;
      ox_d    = ox_q;
      oy_d    = oy_q;
      score_d = score_q;
      hit_d   = 1'b0;
      wc_d    = wc_q;
      go_d    = go_q;

      if (enable && state_q != S_OVER) cnt_d = step ? '0 : cnt_q + CW'(1);

      case (state_q)
         S_MARCH: begin
            if (alive_q == '0) begin
               state_d = S_CLEARED;
               wc_d    = 1'b1;
            end else begin
               if (kill != '0) begin
                  alive_d = alive_q & ~kill;
                  hit_d   = 1'b1;
                  if (score_q != 8'hFF) score_d = score_q + 8'd1;
               end
               if (step) begin
                  if (dir_q == DIR_RIGHT) begin
                     if (right_edge == 6'd31) begin
                        if (oy_q != 4'hF) oy_d = oy_q + 4'd1;
                        dir_d = DIR_LEFT;
                     end else if (ox_q != 5'd31) begin
                        ox_d = ox_q + 5'd1;
                     end
                  end else begin
                     if (left_edge == 6'd0) begin
                        if (oy_q != 4'hF) oy_d = oy_q + 4'd1;
                        dir_d = DIR_RIGHT;
                     end else if (ox_q != 5'd0) begin
                        ox_d = ox_q - 5'd1;
                     end
                  end
               end
               if (land) begin
                  state_d = S_OVER;
                  go_d    = 1'b1;
               end
            end
         end
         S_CLEARED: begin
            if (step) begin
               alive_d = '1;
               ox_d    = '0;
               oy_d    = '0;
               dir_d   = DIR_RIGHT;
               wc_d    = 1'b0;
               state_d = S_MARCH;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk_36MHz) begin
      if (!reset) begin
         state_q <= S_MARCH;
         dir_q   <= DIR_RIGHT;
         cnt_q   <= '0;
         alive_q <= '1;
         ox_q    <= '0;
         oy_q    <= '0;
         score_q <= '0;
         hit_q   <= 1'b0;
         wc_q    <= 1'b0;
         go_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         dir_q   <= dir_d;
         cnt_q   <= cnt_d;
         alive_q <= alive_d;
         ox_q    <= ox_d;
         oy_q    <= oy_d;
         score_q <= score_d;
         hit_q   <= hit_d;
         wc_q    <= wc_d;
         go_q    <= go_d;
      end
   end

   assign bus.hit      = hit_q;
   assign alive        = alive_q;
   assign offset_x     = ox_q;
   assign offset_y     = oy_q;
   assign score        = score_q;
   assign wave_cleared = wc_q;
   assign game_over    = go_q;
   assign dbg_state_o  = state_q;
endmodule

// File: doc/alien_grid.md
Name: alien_grid

Overview:
- Owns the invader formation: alive bitmap, formation position, marching motion, landing detection.
- Sits directly downstream of the player bullet stage. Consumes bullet_flying/bullet_x/bullet_y and detects collisions.
- Returns the one-cycle hit pulse that retires the bullet. Feeds the score and game-over state to the display/control logic.

Parameters:
- ROWS, 4, formation rows (1..8)
- COLS, 8, formation columns (1..8); alien c sits at x = offset_x + 2*c
- STEP_CYCLES, 18000000, clk_36MHz cycles per march step (0.5 s); bench uses 4
- LAND_ROW, 12, screen row at or below which a live alien ends the game

Ports:
- clk_36MHz  in  1  system clock
- reset  in  1  synchronous, active-low
- enable  in  1  1 = step timer runs; 0 = formation frozen (collision still active)
- bullet_flying  in  1  bullet valid
- bullet_x  in  5  bullet column 0..31
- bullet_y  in  4  bullet row 0..15
- hit  out  1  one-cycle pulse, registered
- alive  out  ROWS*COLS  bit r*COLS+c = alien (r,c) alive
- offset_x  out  5  formation left column
- offset_y  out  4  formation top row
- score  out  8  aliens destroyed, saturates at 255
- wave_cleared  out  1  1 for one step period after last alien dies
- game_over  out  1  sticky until reset

Behaviour:
- Reset (reset==0 at posedge), outputs and state:
  - alive = all ones; offset_x = 0; offset_y = 0
  - direction = RIGHT; state = MARCH; hit = 0; score = 0
  - wave_cleared = 0; game_over = 0; step counter = 0
- Reset mid-operation overrides everything in the same edge.
- States: MARCH, CLEARED, OVER.
- Step timer:
  - Counts 0..STEP_CYCLES-1 only when enable==1 and state != OVER.
  - step = (count == STEP_CYCLES-1); counter wraps to 0 on the same edge.
  - enable==0 holds the count.
- Extents, combinational from alive:
  - cmin/cmax = lowest/highest column holding any live alien.
  - rmax = highest row holding any live alien.
- MARCH step, direction RIGHT:
  - If offset_x + 2*cmax == 31: offset_y += 1, direction = LEFT, offset_x unchanged.
  - Else offset_x += 1.
- MARCH step, direction LEFT:
  - If offset_x + 2*cmin == 0: offset_y += 1, direction = RIGHT.
  - Else offset_x -= 1.
  - offset_x arithmetic never wraps.
- Landing:
  - Evaluated every cycle in MARCH on registered values: if alive != 0 and offset_y + rmax >= LAND_ROW, then state = OVER and game_over = 1 next edge.
  - Widen to 5 bits for the compare.
- Collision, evaluated every cycle in MARCH only:
  - col_rel = bullet_x - offset_x, row_rel = bullet_y - offset_y, both signed.
  - Condition: bullet_flying, 0 <= row_rel < ROWS, 0 <= col_rel <= 2*(COLS-1), col_rel even, alive bit (row_rel, col_rel/2) set.
  - On a match at edge N: that alive bit clears, hit = 1, score += 1 (saturating).
  - hit is high during cycle N+1 only.
  - The bit is already clear in cycle N+1, so the still-flying bullet cannot double-score.
  - Bullet between columns (odd col_rel) or outside the formation: no hit.
- Collision and step on the same edge: collision uses pre-step offsets; both updates apply.
- Collision on the same edge as landing: the hit is counted. Landing re-evaluates with the updated alive on the next cycle.
- Wave clear:
  - When alive == 0 in MARCH: state = CLEARED, wave_cleared = 1.
  - On the next step in CLEARED: alive = all ones, offset_x = 0, offset_y = 0, direction = RIGHT, wave_cleared = 0, state = MARCH.
  - Score retained.
- OVER:
  - No stepping, no collisions, hit = 0, all outputs frozen until reset.

Test Plan:
1. Reset with STEP_CYCLES=4, enable=1 -> alive = 0xFFFFFFFF, offsets 0; offset_x increments every 4 cycles. After 16 steps, offset_x=16 (offset_x+14=30 < 31, so another +1 step still occurs). Next steps: offset_x=17, then drop to offset_y=1, direction LEFT. Following step: offset_x=16.
2. Offsets 0/0, bullet_flying=1, bullet_x=4, bullet_y=1 for 3 cycles -> bit 10 clears, hit high exactly 1 cycle, score=1.
3. bullet_x=5 (odd), then bullet_x=20, bullet_y=1 -> no hit, alive unchanged; bullet_flying=0 over a live alien -> no hit.
4. Kill all of column 7 (4 hits) -> right turn occurs at offset_x=19 (offset_x+12 == 31) instead of 17.
5. Force rows 1..3 dead, march until offset_y=12 with row 0 live -> game_over=1, offsets frozen, subsequent bullet over a live alien gives no hit. Reset mid-OVER restores reset values.
6. Kill all 32 aliens -> wave_cleared=1, score=32; next step reloads alive all ones, offsets 0, wave_cleared=0. Hit coinciding with step edge -> hit counted, offset still advances.
